// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction fetch responder: word store, fixed-latency read pipe, in-order response FIFO
//
// Ports:
//   clk_i, rst_i              clock; asynchronous active-low reset (0 = reset)
//   req_valid_i/req_ready_o   fetch request handshake, req_addr_i = byte address (PC)
//   flush_i                   discard every outstanding fetch (redirect)
//   rsp_valid_o/rsp_ready_i   response handshake; rsp_data_o, rsp_addr_o, rsp_err_o
//   init_we_i, init_addr_i,   loader write port into the instruction store
//   init_data_i
//
// Optional feature: define IMEM_ERR_CHECK_EN to fault misaligned or out-of-range fetches.
module imem_responder #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [WIDTH-1:0]      req_addr_i,
    input  logic                  flush_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [WIDTH-1:0]      rsp_data_o,
    output logic [WIDTH-1:0]      rsp_addr_o,
    output logic                  rsp_err_o,
    input  logic                  init_we_i,
    input  logic [DEPTH_LOG2-1:0] init_addr_i,
    input  logic [WIDTH-1:0]      init_data_i
);

    localparam int NSLOT = LATENCY + 1;
    localparam int CW    = $clog2(LATENCY + 2);
    localparam int PW    = $clog2(NSLOT);
    localparam logic [CW-1:0] CNT_MAX = CW'(NSLOT);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    // outstanding fetches: accepted but not yet consumed
    logic [CW-1:0] cnt_q, cnt_d;

    // read pipeline
    logic             pv_q [LATENCY];
    logic [WIDTH-1:0] pd_q [LATENCY];
    logic [WIDTH-1:0] pa_q [LATENCY];
    logic             pe_q [LATENCY];

    // response FIFO
    logic [WIDTH-1:0] fd_q [NSLOT];
    logic [WIDTH-1:0] fa_q [NSLOT];
    logic             fe_q [NSLOT];
    logic [PW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    fcnt_q;

    logic                  accept, rsp_fire, fifo_empty, pipe_out_v, push, pop;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  fetch_err;
    logic [WIDTH-1:0]      fetch_data;
    logic [WIDTH-1:0]      head_data, head_addr;
    logic                  head_err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NSLOT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_idx = req_addr_i[DEPTH_LOG2+1:2];

`ifdef IMEM_ERR_CHECK_EN
    assign fetch_err  = (req_addr_i[1:0] != 2'b00) || (req_addr_i[WIDTH-1:DEPTH_LOG2+2] != '0);
    assign fetch_data = fetch_err ? '0 : mem_q[rd_idx];
`else
    assign fetch_err  = 1'b0;
    assign fetch_data = mem_q[rd_idx];
`endif

    // rst_i term keeps ready low while reset is held even though cnt_q is already 0
    assign req_ready_o = rst_i && (cnt_q < CNT_MAX) && !flush_i && !init_we_i;
    assign accept      = req_valid_i && req_ready_o;

    assign fifo_empty = (fcnt_q == '0);
    assign pipe_out_v = pv_q[LATENCY-1];

    // An empty FIFO is bypassed so the last pipe stage is presented in the
    // same cycle it becomes valid; anything already queued is older.
    assign head_data = fifo_empty ? pd_q[LATENCY-1] : fd_q[rp_q];
    assign head_addr = fifo_empty ? pa_q[LATENCY-1] : fa_q[rp_q];
    assign head_err  = fifo_empty ? pe_q[LATENCY-1] : fe_q[rp_q];

    assign rsp_valid_o = !flush_i && (!fifo_empty || pipe_out_v);
    assign rsp_data_o  = rsp_valid_o ? head_data : '0;
    assign rsp_addr_o  = rsp_valid_o ? head_addr : '0;
    assign rsp_err_o   = rsp_valid_o ? head_err  : 1'b0;

    assign rsp_fire = rsp_valid_o && rsp_ready_i;
    assign pop      = rsp_fire && !fifo_empty;
    // a pipe output consumed straight through the bypass is never queued
    assign push     = pipe_out_v && !(fifo_empty && rsp_fire);

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !rsp_fire && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && rsp_fire && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q  <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pv_q[k] <= 1'b0;
            end
        end else if (flush_i) begin
            cnt_q  <= '0;
            wp_q   <= '0;
            rp_q   <= '0;
            fcnt_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pv_q[k] <= 1'b0;
            end
        end else begin
            cnt_q   <= cnt_d;
            pv_q[0] <= accept;
            for (int k = 1; k < LATENCY; k++) begin
                pv_q[k] <= pv_q[k-1];
            end
            if (push) begin
                wp_q <= ptr_inc(wp_q);
            end
            if (pop) begin
                rp_q <= ptr_inc(rp_q);
            end
            if (push && !pop) begin
                fcnt_q <= fcnt_q + 1'b1;
            end else if (!push && pop) begin
                fcnt_q <= fcnt_q - 1'b1;
            end
        end
    end

    // Payload registers carry no reset; the valids above qualify them and
    // the outputs are zeroed whenever nothing is presented.
    always_ff @(posedge clk_i) begin
        pd_q[0] <= fetch_data;
        pa_q[0] <= req_addr_i;
        pe_q[0] <= fetch_err;
        for (int k = 1; k < LATENCY; k++) begin
            pd_q[k] <= pd_q[k-1];
            pa_q[k] <= pa_q[k-1];
            pe_q[k] <= pe_q[k-1];
        end
        if (push) begin
            fd_q[wp_q] <= pd_q[LATENCY-1];
            fa_q[wp_q] <= pa_q[LATENCY-1];
            fe_q[wp_q] <= pe_q[LATENCY-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (init_we_i) begin
            mem_q[init_addr_i] <= init_data_i;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder
module tb_imem_responder;

    localparam int WIDTH = 32;
    localparam int DL    = 8;
    localparam int LAT   = 2;
    localparam int NOUT  = LAT + 1;

    logic          clk;
    logic          rst_n;
    logic          req_valid, req_ready, flush, rsp_valid, rsp_ready, rsp_err, init_we;
    logic [31:0]   req_addr, rsp_data, rsp_addr, init_data;
    logic [DL-1:0] init_addr;

    imem_responder #(.WIDTH(WIDTH), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .flush_i(flush),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_addr_o(rsp_addr), .rsp_err_o(rsp_err),
        .init_we_i(init_we), .init_addr_i(init_addr), .init_data_i(init_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          due;
    } rsp_t;

    rsp_t        mq[$];
    rsp_t        cap[$];
    logic [31:0] mmem [2**DL];
    int          cyc   = 0;
    int          n_acc = 0;
    logic        m_acc, m_hs;

    function automatic logic exp_ready();
        return rst_n && (mq.size() < NOUT) && !flush && !init_we;
    endfunction

    function automatic logic exp_valid();
        return rst_n && !flush && (mq.size() > 0) && (cyc >= mq[0].due);
    endfunction

    function automatic rsp_t make_rsp(input logic [31:0] a, input int c);
        rsp_t r;
        logic e;
`ifdef IMEM_ERR_CHECK_EN
        e = (a % 4 != 0) || (a >= 32'(4 * (2**DL)));
`else
        e = 1'b0;
`endif
        r.addr = a;
        r.err  = e;
        r.data = e ? 32'h0 : mmem[(a / 4) % (2**DL)];
        r.due  = c + LAT;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            m_acc = exp_ready() && req_valid;
            m_hs  = exp_valid() && rsp_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_hs) void'(mq.pop_front());
                if (m_acc) mq.push_back(make_rsp(req_addr, cyc));
            end
            if (init_we) mmem[init_addr] = init_data;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_req_ready", 32'(req_ready), 32'd0);
            check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
            check("reset_rsp_data", rsp_data, 32'd0);
            check("reset_rsp_addr", rsp_addr, 32'd0);
            check("reset_rsp_err", 32'(rsp_err), 32'd0);
        end else begin
            check("req_ready", 32'(req_ready), 32'(exp_ready()));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid()));
            if (exp_valid()) begin
                check("rsp_data", rsp_data, mq[0].data);
                check("rsp_addr", rsp_addr, mq[0].addr);
                check("rsp_err", 32'(rsp_err), 32'(mq[0].err));
            end
            if (rsp_valid && rsp_ready) cap.push_back('{rsp_addr, rsp_data, rsp_err, cyc});
            if (req_valid && req_ready) n_acc++;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    logic [31:0] prog [4];
    vec_t        vecs [6];
    int          base;
    int          acc0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_caps(input string name, input int n);
        for (int i = 0; i < 30 && cap.size() < n; i++) tick();
        check(name, 32'(cap.size()), 32'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prog[0] = 32'h20080001;
        prog[1] = 32'h20090002;
        prog[2] = 32'h01095020;
        prog[3] = 32'h08000000;
        vecs[0] = '{32'h0, prog[0], 1'b0};
        vecs[1] = '{32'h4, prog[1], 1'b0};
        vecs[2] = '{32'h8, prog[2], 1'b0};
        vecs[3] = '{32'hC, prog[3], 1'b0};
`ifdef IMEM_ERR_CHECK_EN
        vecs[4] = '{32'h400, 32'h0, 1'b1};
        vecs[5] = '{32'h2, 32'h0, 1'b1};
`else
        vecs[4] = '{32'h400, prog[0], 1'b0};
        vecs[5] = '{32'h2, prog[0], 1'b0};
`endif

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        rsp_ready = 1'b0; init_we = 1'b0; init_addr = '0; init_data = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        tick();

        for (int i = 0; i < 2**DL; i++) begin
            init_we   = 1'b1;
            init_addr = DL'(i);
            init_data = (i < 4) ? prog[i] : $urandom;
            tick();
        end
        init_we = 1'b0;

        // program fetch table, back-to-back with rsp_ready held high
        rsp_ready = 1'b1;
        base = cap.size();
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr  = vecs[i].addr;
            tick();
        end
        req_valid = 1'b0;
        wait_caps("table_count", base + 6);
        for (int i = 0; i < 6; i++) begin
            if (cap.size() > base + i) begin
                check("table_addr", cap[base+i].addr, vecs[i].addr);
                check("table_data", cap[base+i].data, vecs[i].data);
                check("table_err", 32'(cap[base+i].err), 32'(vecs[i].err));
            end
        end

        // backpressure: exactly LAT+1 accepts, then one pop reopens the port
        rsp_ready = 1'b0;
        n_acc = 0;
        base = cap.size();
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h10 + 32'(4 * n_acc);
            tick();
        end
        req_valid = 1'b0;
        check("bp_accepts", 32'(n_acc), 32'(NOUT));
        @(negedge clk);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_back", 32'(req_ready), 32'd1);
        tick();
        rsp_ready = 1'b1;
        wait_caps("bp_count", base + NOUT);
        for (int i = 0; i < NOUT; i++) begin
            if (cap.size() > base + i) begin
                check("bp_order_addr", cap[base+i].addr, 32'h10 + 32'(4 * i));
                check("bp_order_data", cap[base+i].data, mmem[4 + i]);
            end
        end

        // flush on the cycle the first fetch would be presented
        base = cap.size();
        req_valid = 1'b1; req_addr = 32'h0; tick();
        req_addr = 32'h4; tick();
        req_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0; req_valid = 1'b1; req_addr = 32'h8; tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("flush_gap_valid", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        check("flush_next_valid", 32'(rsp_valid), 32'd1);
        check("flush_next_data", rsp_data, 32'h01095020);
        tick(); tick();
        check("flush_rsp_count", 32'(cap.size()), 32'(base + 1));
        if (cap.size() > base) check("flush_rsp_addr", cap[base].addr, 32'h8);

        // asynchronous reset with two fetches outstanding
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h20; tick();
        req_addr = 32'h24; tick();
        req_valid = 1'b0; tick();
        @(negedge clk);
        check("prereset_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_rsp_data", rsp_data, 32'd0);
        check("async_rsp_addr", rsp_addr, 32'd0);
        check("async_req_ready", 32'(req_ready), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        base = cap.size();
        @(negedge clk);
        check("post_reset_ready", 32'(req_ready), 32'd1);
        repeat (5) tick();
        check("no_stale_rsp", 32'(cap.size()), 32'(base));

        // loader write competes with a request
        base = cap.size();
        init_we = 1'b1; init_addr = 8'd5; init_data = 32'hDEADBEEF;
        req_valid = 1'b1; req_addr = 32'h14;
        acc0 = n_acc;
        @(negedge clk);
        check("init_blocks_ready", 32'(req_ready), 32'd0);
        check("init_no_accept", 32'(n_acc), 32'(acc0));
        tick();
        init_we = 1'b0;
        tick();
        req_valid = 1'b0;
        wait_caps("init_rsp_count", base + 1);
        if (cap.size() > base) check("init_new_data", cap[base].data, 32'hDEADBEEF);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom % 10) < 7;
            req_addr  = (($urandom % 8) == 0) ? 32'($urandom) : (32'($urandom) & 32'h3FC);
            rsp_ready = ($urandom % 10) < 6;
            flush     = ($urandom % 25) == 0;
            init_we   = ($urandom % 20) == 0;
            init_addr = DL'($urandom);
            init_data = $urandom;
            tick();
        end
        req_valid = 1'b0; flush = 1'b0; init_we = 1'b0; rsp_ready = 1'b1;
        repeat (10) tick();
        @(negedge clk);
        check("drained_valid", 32'(rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Responder end of the fetch interface: accepts instruction fetch requests from the IF stage over a valid/ready handshake and returns instruction words in order. Each response arrives after a fixed, parameterised latency. Internally it holds a word-addressed instruction store, a LATENCY-deep read pipeline and an in-order response FIFO. It supports pipeline flush on redirect (branch/jump/EPC) and a loader write port for filling the store before execution.

## Interface
- WIDTH, 32, address/data width
- DEPTH_LOG2, 8, log2 of store size in words (256 words)
- LATENCY, 2, cycles from request acceptance to earliest rsp_valid; legal 1..4

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- req_valid  input  1  IF presents a fetch
- req_ready  output  1  responder can accept this cycle
- req_addr  input  WIDTH  byte address of fetch (PC)
- flush  input  1  discard all outstanding fetches (redirect)
- rsp_valid  output  1  response at FIFO head
- rsp_ready  input  1  IF consumes response
- rsp_data  output  WIDTH  instruction word
- rsp_addr  output  WIDTH  address the response belongs to
- rsp_err  output  1  fetch fault (misaligned or out of range)
- init_we  input  1  loader write strobe
- init_addr  input  DEPTH_LOG2  word index for loader write
- init_data  input  WIDTH  loader write data

## Operation
- Request accepted on an edge where req_valid && req_ready.
- req_ready = (cnt < LATENCY+1) && !flush && !init_we.
- cnt is the outstanding counter: accepted but not yet consumed. Reset 0.
  - +1 on accept, -1 on response handshake, unchanged when both occur.
  - Saturates at LATENCY+1.
- Word index = req_addr[DEPTH_LOG2+1:2]. The store is read at acceptance and the word carried down a LATENCY-stage pipeline with addr and err.
- Pipeline output is written to a response FIFO of depth LATENCY+1. The FIFO cannot overflow given the cnt bound, so there is no backpressure into the pipeline.
- Responses are delivered strictly in acceptance order.
- Response handshake: rsp_valid && rsp_ready pops the FIFO head. rsp_data, rsp_addr and rsp_err hold stable while rsp_valid && !rsp_ready.
- Faulted fetch (see Configuration): rsp_err=1, rsp_data=0, still one in-order response.
- flush=1:
  - req_ready=0 and rsp_valid forced 0 combinationally; no handshake can complete that cycle.
  - At the edge, all pipeline valids clear, the FIFO empties and cnt goes to 0.
  - Requests are accepted again the following cycle if flush is low.
- init_we=1: writes init_data to store[init_addr] at the edge. req_ready=0 that cycle. In-flight reads are unaffected (already captured).
- Store contents are not reset.
- Reset (rst=0), any cycle including mid-transfer: pipeline and FIFO empty, cnt=0, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_err=0, req_ready=0. After release, req_ready=1 from the first cycle.

## Timing
- Request accepted at edge E: rsp_valid=1 in the cycle after edge E+LATENCY-1 (LATENCY cycles later), if no older responses are pending.
- Back-to-back requests with rsp_ready held 1 sustain one response per cycle.
- With rsp_ready=0, exactly LATENCY+1 requests are accepted, then req_ready drops.
- req_ready reasserts the cycle after the first consuming handshake.
- Simultaneous flush and request or response handshake: flush wins; neither handshake takes effect.

## Configuration
- IMEM_ERR_CHECK_EN defined:
  - rsp_err=1 when req_addr[1:0]!=0 or req_addr[WIDTH-1:DEPTH_LOG2+2]!=0.
  - rsp_data forced to 0 for those fetches.
- IMEM_ERR_CHECK_EN undefined:
  - rsp_err tied 0.
  - Low two bits and bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo 2^(DEPTH_LOG2+2).

## Test plan
- Load store[0..3]=0x20080001,0x20090002,0x01095020,0x08000000; fetch 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1 -> four responses in order with matching rsp_addr; first rsp_valid 2 cycles after first accept; then one per cycle.
- rsp_ready=0, req_valid held -> exactly 3 accepts (LATENCY=2), req_ready=0. One pop -> req_ready=1 next cycle; all data in order.
- Fetch 0x0 and 0x4 accepted, flush on the cycle 0x0 would be presented -> no response for either; next fetch 0x8 returns 0x01095020 after 2 cycles.
- With IMEM_ERR_CHECK_EN: fetch 0x2 -> rsp_err=1, rsp_data=0. Fetch 0x400 -> rsp_err=1. Without the macro, fetch 0x400 -> rsp_err=0, data = store[0].
- Assert rst=0 mid-stream with 2 outstanding -> outputs 0 asynchronously. After release, req_ready=1 and no stale response appears.
- init_we with req_valid same cycle -> req_ready=0, no accept. A subsequent fetch of the written address returns the new data.
